// File: rtl/timebase_gen.sv
// timebase_gen: three-stage cascaded timebase producing single-cycle enable
// strobes at exact integer divide ratios of CLK (fast, slow, minute).
// All outputs are registered and synchronous to CLK; no derived clocks.
//
// Build option: define TIMEBASE_SQUARE_EN to add SQ_FAST/SQ_SLOW debug
// square-wave outputs (for scope/LED observation only, never a clock).
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   EN         count enable; low pauses all stages (counters hold)
//   CLR        synchronous restart of all stages, overrides EN
//   TICK_FAST  strobe every DIV_FAST enabled cycles
//   TICK_SLOW  strobe every DIV_FAST*DIV_SLOW enabled cycles
//   TICK_MIN   strobe every DIV_FAST*DIV_SLOW*DIV_MIN enabled cycles
//   SEC_CNT    current slow-stage count, 0..DIV_MIN-1
//   SQ_FAST    (option) high while fast count < DIV_FAST/2
//   SQ_SLOW    (option) high while slow count < DIV_SLOW/2
module timebase_gen #(
   parameter  int unsigned DIV_FAST = 15,
   parameter  int unsigned DIV_SLOW = 800000,
   parameter  int unsigned DIV_MIN  = 60,
   localparam int unsigned W0       = $clog2(DIV_FAST),
   localparam int unsigned W1       = $clog2(DIV_SLOW),
   localparam int unsigned W2       = $clog2(DIV_MIN)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          CLR,
   output logic          TICK_FAST,
   output logic          TICK_SLOW,
   output logic          TICK_MIN,
   output logic [W2-1:0] SEC_CNT
`ifdef TIMEBASE_SQUARE_EN
   ,
   output logic          SQ_FAST,
   output logic          SQ_SLOW
`endif
);

   // Reject divide ratios that cannot produce a single-cycle strobe
   generate
      if (DIV_FAST < 2 || DIV_SLOW < 2 || DIV_MIN < 2) begin : g_bad_div
         $error("timebase_gen: every DIV_* parameter must be >= 2");
      end
   endgenerate

   localparam logic [W0-1:0] LAST0 = W0'(DIV_FAST - 1);
   localparam logic [W1-1:0] LAST1 = W1'(DIV_SLOW - 1);
   localparam logic [W2-1:0] LAST2 = W2'(DIV_MIN - 1);

   logic [W0-1:0] c0, c0_n;
   logic [W1-1:0] c1, c1_n;
   logic [W2-1:0] c2, c2_n;
   logic          tick_fast_n, tick_slow_n, tick_min_n;
   logic          wrap0, wrap1, wrap2;

   // Stage wrap conditions; each stage only advances when the one below wraps
   always_comb begin
      wrap0 = (c0 == LAST0);
      wrap1 = wrap0 && (c1 == LAST1);
      wrap2 = wrap1 && (c2 == LAST2);
   end

   // Next-state and strobe logic; CLR beats EN, a pause forces strobes low
   always_comb begin
      c0_n        = c0;
      c1_n        = c1;
      c2_n        = c2;
      tick_fast_n = 1'b0;
      tick_slow_n = 1'b0;
      tick_min_n  = 1'b0;
      if (CLR) begin
         c0_n = '0;
         c1_n = '0;
         c2_n = '0;
      end else if (EN) begin
         c0_n        = wrap0 ? '0 : c0 + W0'(1);
         tick_fast_n = wrap0;
         tick_slow_n = wrap1;
         tick_min_n  = wrap2;
         if (wrap0) begin
            c1_n = wrap1 ? '0 : c1 + W1'(1);
         end
         if (wrap1) begin
            c2_n = wrap2 ? '0 : c2 + W2'(1);
         end
      end
   end

   // State and strobe registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c0        <= '0;
         c1        <= '0;
         c2        <= '0;
         TICK_FAST <= 1'b0;
         TICK_SLOW <= 1'b0;
         TICK_MIN  <= 1'b0;
      end else begin
         c0        <= c0_n;
         c1        <= c1_n;
         c2        <= c2_n;
         TICK_FAST <= tick_fast_n;
         TICK_SLOW <= tick_slow_n;
         TICK_MIN  <= tick_min_n;
      end
   end

   // c2 is itself a register updated on the TICK_SLOW edge
   assign SEC_CNT = c2;

`ifdef TIMEBASE_SQUARE_EN
   // Square outputs track the next counter values so they stay aligned with c0/c1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         SQ_FAST <= 1'b1;
         SQ_SLOW <= 1'b1;
      end else begin
         SQ_FAST <= (c0_n < W0'(DIV_FAST / 2));
         SQ_SLOW <= (c1_n < W1'(DIV_SLOW / 2));
      end
   end
`endif

endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: directed bench for timebase_gen with small divide ratios
// (3/4/5). A reference model tracks the total enabled-cycle count n (mod 60)
// and derives expected strobes and SEC_CNT from it; expectations are queued
// when each step is driven and popped after the following clock edge.
module tb_timebase_gen;

   localparam int unsigned DF  = 3;
   localparam int unsigned DS  = 4;
   localparam int unsigned DM  = 5;
   localparam int unsigned TOT = DF * DS * DM;

   typedef struct {
      logic       tf;
      logic       ts;
      logic       tm;
      logic [2:0] sec;
      logic       sqf;
      logic       sqs;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST;
   logic       EN;
   logic       CLR;
   logic       TICK_FAST;
   logic       TICK_SLOW;
   logic       TICK_MIN;
   logic [2:0] SEC_CNT;
`ifdef TIMEBASE_SQUARE_EN
   logic       SQ_FAST;
   logic       SQ_SLOW;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   n        = 0;
   exp_t sb[$];

   timebase_gen #(
      .DIV_FAST(DF),
      .DIV_SLOW(DS),
      .DIV_MIN (DM)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .EN       (EN),
      .CLR      (CLR),
      .TICK_FAST(TICK_FAST),
      .TICK_SLOW(TICK_SLOW),
      .TICK_MIN (TICK_MIN),
      .SEC_CNT  (SEC_CNT)
`ifdef TIMEBASE_SQUARE_EN
      ,
      .SQ_FAST  (SQ_FAST),
      .SQ_SLOW  (SQ_SLOW)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t n=%0d)", tag, obs, expv, $time, n);
      end
   endtask

   // Drive one cycle of stimulus, queue the model's prediction, compare after the edge
   task automatic step(input logic en, input logic clr);
      exp_t e;
      exp_t got;
      EN  = en;
      CLR = clr;
      e.tf = 1'b0;
      e.ts = 1'b0;
      e.tm = 1'b0;
      if (RST || clr) begin
         n = 0;
      end else if (en) begin
         n    = (n + 1) % TOT;
         e.tf = (n % DF) == 0;
         e.ts = (n % (DF * DS)) == 0;
         e.tm = (n == 0);
      end
      e.sec = 3'(n / (DF * DS));
      e.sqf = (n % DF) < (DF / 2);
      e.sqs = ((n / DF) % DS) < (DS / 2);
      sb.push_back(e);
      @(posedge CLK);
      #1;
      got = sb.pop_front();
      cmp("tick_fast", 8'(TICK_FAST), 8'(got.tf));
      cmp("tick_slow", 8'(TICK_SLOW), 8'(got.ts));
      cmp("tick_min",  8'(TICK_MIN),  8'(got.tm));
      cmp("sec_cnt",   8'(SEC_CNT),   8'(got.sec));
`ifdef TIMEBASE_SQUARE_EN
      cmp("sq_fast",   8'(SQ_FAST),   8'(got.sqf));
      cmp("sq_slow",   8'(SQ_SLOW),   8'(got.sqs));
`endif
   endtask

   // Run enabled cycles until the model count reaches target, bounded
   task automatic run_until(input int target);
      int k;
      k = 0;
      while (n != target && k < 200) begin
         step(1'b1, 1'b0);
         k++;
      end
      cmp("run_until_reached", 8'(n == target), 8'd1);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
   endtask

   initial begin
      RST = 1'b1;
      EN  = 1'b1;
      CLR = 1'b0;

      // Reset held with EN high: everything stays zero
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      RST = 1'b0;

      // Free run past two minute wraps: ticks at 3k, 12k, 60k
      run(130);

      // Pause 7 cycles with c0 == 1
      run_until(TOT - 2);
      run(3);
      cmp("c0_is_one_before_pause", 8'(n % DF), 8'd1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
      run(20);

      // CLR with EN on the edge where c0 would wrap, SEC_CNT nonzero beforehand
      run_until(26);
      cmp("sec_nonzero_before_clr", 8'(SEC_CNT), 8'd2);
      step(1'b1, 1'b1);
      run(10);

      // CLR while paused also restarts
      run_until(14);
      step(1'b0, 1'b1);
      run(5);

      // Asynchronous reset between edges: outputs clear without a clock edge
      run_until(36);
      RST = 1'b1;
      #2;
      cmp("async_rst_tick_fast", 8'(TICK_FAST), 8'd0);
      cmp("async_rst_tick_slow", 8'(TICK_SLOW), 8'd0);
      cmp("async_rst_tick_min",  8'(TICK_MIN),  8'd0);
      cmp("async_rst_sec_cnt",   8'(SEC_CNT),   8'd0);
`ifdef TIMEBASE_SQUARE_EN
      cmp("async_rst_sq_fast",   8'(SQ_FAST),   8'd1);
`endif
      step(1'b1, 1'b0);
      RST = 1'b0;
      run(130);

      cmp("scoreboard_empty", 8'(sb.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
